// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} arb_state_t;
    typedef enum logic {REQ_IF, REQ_DATA} requester_t;

    localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; the pointer remembers the last granted requester.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       req_if,
    input  logic       req_d,
    input  logic       update,
    output requester_t gnt,
    output logic       any
);

    requester_t last_gnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_gnt <= REQ_DATA;
        end else if (update) begin
            last_gnt <= gnt;
        end
    end

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt = REQ_IF;
        if (req_if && req_d) begin
            gnt = (last_gnt == REQ_IF) ? REQ_DATA : REQ_IF;
        end else if (req_d) begin
            gnt = REQ_DATA;
        end
    end

    assign any = req_if | req_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters, with a
// watchdog that turns a missing acknowledge into a sticky error plus dummy response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic [3:0]            d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_valid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  err_o
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    arb_state_t            state, next_state;
    requester_t            gnt, owner;
    logic                  req_any, grant, capture, timeout, busy;
    logic [WD_W-1:0]       wd;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            we_q;
    logic [DATA_WIDTH-1:0] wdata_q, if_rdata_q, d_rdata_q, resp_data;
    logic                  err_q;

    rr_arb2 u_rr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_if (if_req_i),
        .req_d  (d_req_i),
        .update (grant),
        .gnt    (gnt),
        .any    (req_any)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    grant      = 1'b1;
                    next_state = (gnt == REQ_IF) ? BUSY_IF : BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                // An ack in the final watchdog cycle still counts as success.
                if (mem_ack_i) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else if (wd == WD_LAST) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy      = (state == BUSY_IF) || (state == BUSY_D);
    assign resp_data = capture ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner      <= REQ_IF;
            wd         <= '0;
            addr_q     <= '0;
            we_q       <= WE_NONE;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant) begin
                owner <= gnt;
                wd    <= '0;
                if (gnt == REQ_IF) begin
                    addr_q  <= if_addr_i;
                    we_q    <= WE_NONE;
                    wdata_q <= '0;
                end else begin
                    addr_q  <= d_addr_i;
                    we_q    <= d_we_i;
                    wdata_q <= d_wdata_i;
                end
            end
            if (busy && !mem_ack_i) wd <= wd + WD_ONE;
            if (capture || timeout) begin
                if (owner == REQ_IF) if_rdata_q <= resp_data;
                else                 d_rdata_q  <= resp_data;
            end
            if (timeout) err_q <= 1'b1;
        end
    end

    assign mem_req_o   = busy;
    assign mem_addr_o  = busy ? addr_q  : '0;
    assign mem_we_o    = busy ? we_q    : WE_NONE;
    assign mem_wdata_o = busy ? wdata_q : '0;
    assign if_valid_o  = (state == RESP) && (owner == REQ_IF);
    assign d_valid_o   = (state == RESP) && (owner == REQ_DATA);
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, store latching,
// watchdog timeout and its ack tie-break, and asynchronous reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_valid_o  (if_valid),
        .if_rdata_o  (if_rdata),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_valid_o   (d_valid),
        .d_rdata_o   (d_rdata),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From IDLE with requests up: grant, ack on the first BUSY cycle, response, back to IDLE.
    task automatic serve(input string tag, input bit exp_if, input logic [31:0] exp_addr,
                         input logic [31:0] rd);
        step();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack = 1'b0;
        chk({tag, "_ifv"}, 32'(if_valid), 32'(exp_if));
        chk({tag, "_dv"}, 32'(d_valid), 32'(!exp_if));
        chk({tag, "_rdata"}, exp_if ? if_rdata : d_rdata, rd);
        chk({tag, "_req_resp"}, 32'(mem_req), 32'd0);
        step();
        chk({tag, "_ifv_idle"}, 32'(if_valid), 32'd0);
        chk({tag, "_dv_idle"}, 32'(d_valid), 32'd0);
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ifv", 32'(if_valid), 32'd0);
        chk("rst_dv", 32'(d_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ifrd", if_rdata, 32'd0);
        rstn = 1'b1;
        step();

        // 1: fetch only, ack two cycles after mem_req rises
        if_req  = 1'b1;
        if_addr = 32'h100;
        step();
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_we", 32'(mem_we), 32'd0);
        step();
        chk("t1_req_c2", 32'(mem_req), 32'd1);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        chk("t1_ifv", 32'(if_valid), 32'd1);
        chk("t1_ifrd", if_rdata, 32'hDEADBEEF);
        chk("t1_dv", 32'(d_valid), 32'd0);
        chk("t1_req_resp", 32'(mem_req), 32'd0);
        step();
        chk("t1_ifv_once", 32'(if_valid), 32'd0);
        chk("t1_ifrd_hold", if_rdata, 32'hDEADBEEF);
        chk("t1_dv_idle", 32'(d_valid), 32'd0);

        // 2: simultaneous requests after reset alternate IF, D, IF, D
        rstn = 1'b0;
        step();
        rstn    = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_we    = 4'b0000;
        d_addr  = 32'h2000;
        serve("t2_g1", 1'b1, 32'h10, 32'h11111111);
        serve("t2_g2", 1'b0, 32'h2000, 32'h22222222);
        serve("t2_g3", 1'b1, 32'h10, 32'h33333333);
        serve("t2_g4", 1'b0, 32'h2000, 32'h44444444);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // 3: store, requester address changes after grant
        d_req   = 1'b1;
        d_we    = 4'b0011;
        d_addr  = 32'h2004;
        d_wdata = 32'h1234;
        step();
        d_addr = 32'hFFFF;
        chk("t3_addr", mem_addr, 32'h2004);
        chk("t3_we", 32'(mem_we), 32'h3);
        chk("t3_wdata", mem_wdata, 32'h1234);
        step();
        chk("t3_addr_hold", mem_addr, 32'h2004);
        chk("t3_wdata_hold", mem_wdata, 32'h1234);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD0BAD;
        step();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 4'b0000;
        chk("t3_dv", 32'(d_valid), 32'd1);
        chk("t3_ifv", 32'(if_valid), 32'd0);
        step();
        chk("t3_dv_once", 32'(d_valid), 32'd0);

        // 4: load with no ack times out after 16 BUSY cycles
        d_req  = 1'b1;
        d_addr = 32'h3000;
        step();
        for (int i = 1; i < 16; i++) step();
        chk("t4_req_c16", 32'(mem_req), 32'd1);
        chk("t4_err_c16", 32'(err), 32'd0);
        step();
        d_req = 1'b0;
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_dv", 32'(d_valid), 32'd1);
        chk("t4_drd", d_rdata, 32'd0);
        chk("t4_req", 32'(mem_req), 32'd0);
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        chk("t4_late_req", 32'(mem_req), 32'd0);
        chk("t4_late_dv", 32'(d_valid), 32'd0);
        chk("t4_late_drd", d_rdata, 32'd0);
        step();
        chk("t4_late_dv2", 32'(d_valid), 32'd0);
        chk("t4_late_ifv", 32'(if_valid), 32'd0);
        if_req  = 1'b1;
        if_addr = 32'h40;
        serve("t4_fetch", 1'b1, 32'h40, 32'h0000CAFE);
        if_req = 1'b0;
        chk("t4_err_sticky", 32'(err), 32'd1);

        // 6: asynchronous reset mid-BUSY_D, then fetch wins first
        d_req  = 1'b1;
        d_addr = 32'h600;
        step();
        chk("t6_req_busy", 32'(mem_req), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_req_async", 32'(mem_req), 32'd0);
        chk("t6_addr_async", mem_addr, 32'd0);
        chk("t6_err_async", 32'(err), 32'd0);
        chk("t6_dv_async", 32'(d_valid), 32'd0);
        chk("t6_ifv_async", 32'(if_valid), 32'd0);
        step();
        rstn    = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h80;
        d_addr  = 32'h604;
        serve("t6_first", 1'b1, 32'h80, 32'h66666666);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // 5: ack in the 16th BUSY cycle beats the timeout
        d_req  = 1'b1;
        d_addr = 32'h500;
        step();
        for (int i = 1; i < 16; i++) step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555AAAA;
        step();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        chk("t5_dv", 32'(d_valid), 32'd1);
        chk("t5_drd", d_rdata, 32'h5555AAAA);
        chk("t5_err", 32'(err), 32'd0);
        step();
        chk("t5_err_after", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port between the instruction-fetch requester and the load/store data requester of the multi-cycle core. Uses round-robin selection, latches the winning request, and holds it on the memory port until acknowledge. Returns read data through a one-cycle response pulse. A watchdog converts a missing memory acknowledge into a sticky error plus a dummy response, so the core controller never hangs.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 16, maximum BUSY cycles without mem_ack_i before timeout (must be >=2)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request, held high until if_valid_o
if_addr_i  in  ADDR_WIDTH  fetch address
if_valid_o  out  1  one-cycle fetch response strobe
if_rdata_o  out  DATA_WIDTH  fetch data, valid when if_valid_o
d_req_i  in  1  data request, held high until d_valid_o
d_we_i  in  4  byte write strobes; 0 = load
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  DATA_WIDTH  store data
d_valid_o  out  1  one-cycle data response strobe
d_rdata_o  out  DATA_WIDTH  load data, valid when d_valid_o
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  4  memory byte strobes
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data, sampled with mem_ack_i
mem_ack_i  in  1  memory acknowledge, single-cycle
err_o  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; state IDLE; last_gnt = DATA, so fetch wins first; watchdog 0; latches 0.
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE:
  - Only if_req_i -> BUSY_IF. Only d_req_i -> BUSY_D.
  - Both -> grant the requester not equal to last_gnt.
  - On grant: latch addr/we/wdata, update last_gnt, clear watchdog.
- BUSY_IF / BUSY_D:
  - mem_req_o = 1. mem_addr_o, mem_we_o and mem_wdata_o driven from the latches only; requester inputs are ignored after grant.
  - mem_we_o is forced to 0 for fetch.
  - Watchdog increments each cycle without ack.
- On mem_ack_i in BUSY: capture mem_rdata_i into the response register -> RESP. Store acks also capture; the data is don't-care.
- Watchdog reaches TIMEOUT_CYCLES without ack: set err_o, response register = 0 -> RESP.
- Ack and timeout in the same cycle: ack wins, err_o unchanged.
- RESP:
  - Exactly one cycle.
  - The granted requester's valid_o = 1 with rdata_o from the response register; the other requester's valid_o = 0.
  - mem_req_o = 0. New requests are ignored this cycle. Next state IDLE.
- rdata outputs hold their last value outside RESP.
- Latency: request seen in IDLE at cycle 0 -> mem_req_o from cycle 1 -> ack at cycle k (k>=1) -> valid at cycle k+1 -> IDLE at k+2. Minimum 3 cycles per access.
- mem_ack_i outside BUSY (late ack after timeout, spurious ack) is ignored with no state change.
- err_o clears only on reset.
- Reset mid-transaction: asynchronous return to reset values; mem_req_o falls without waiting for a clock edge; no response is issued.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_D, RESP)
  - requester_t enum (REQ_IF, REQ_DATA)
  - WE_NONE = 4'b0000
- Sub-module rr_arb2: a 2-input round-robin picker with a registered last_gnt pointer and update-on-grant input. The watchdog stays inline.

Test Plan:
1. Fetch only: if_req_i, addr 0x100; ack 2 cycles after mem_req_o rises with rdata 0xDEADBEEF -> mem_we_o = 0; if_valid_o high for exactly 1 cycle with 0xDEADBEEF; d_valid_o stays 0.
2. Simultaneous requests after reset, fetch 0x10 and load 0x2000 -> fetch served first, then data. Repeat with both held -> grants alternate IF, D, IF, D.
3. Store: d_we_i = 0011, addr 0x2004, wdata 0x1234; d_addr_i changed to 0xFFFF after grant -> mem_addr_o stays 0x2004; mem_we_o = 0011; mem_wdata_o = 0x1234 until ack; d_valid_o pulses once.
4. Timeout: load with no ack -> after 16 BUSY cycles err_o = 1, d_valid_o pulses with 0, mem_req_o = 0. An ack arriving 3 cycles later is ignored. err_o stays 1 across the next successful fetch.
5. Ack in the 16th BUSY cycle, the same cycle as the timeout -> data returned, err_o stays 0.
6. rstn_i low mid-BUSY_D -> mem_req_o, valid outputs and err_o go 0 immediately. After release, a both-requests case grants fetch first.
